// File: rtl/pzcorebus_response_buffer.sv
// rtl/pzcorebus_response_buffer.sv - response beat FIFO with optional per-packet store-and-forward
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_s_valid/o_s_ready/i_s_id/i_s_data/i_s_last   upstream beat stream
//   o_m_valid/i_m_ready/o_m_id/o_m_data/o_m_last   downstream beat stream
//   o_empty, o_full                   buffer status
//   o_occupancy, o_packet_count       registered counters, present only with
//                                     PZCOREBUS_RESPONSE_BUFFER_STATUS_EN defined
//
// PACKET_MODE=1 holds beats until a complete packet (or a full buffer) is stored.

module pzcorebus_response_buffer #(
   parameter int ID_WIDTH    = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int PACKET_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   input  logic [ID_WIDTH-1:0]   i_s_id,
   input  logic [DATA_WIDTH-1:0] i_s_data,
   input  logic                  i_s_last,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [ID_WIDTH-1:0]   o_m_id,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_last,
   output logic                  o_empty,
   output logic                  o_full
`ifdef PZCOREBUS_RESPONSE_BUFFER_STATUS_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
   output logic [$clog2(DEPTH+1)-1:0] o_packet_count
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = ID_WIDTH + DATA_WIDTH + 1;

   typedef enum logic {HOLD, FORWARD} state_t;

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [CW-1:0] pkt_count;
   logic [CW-1:0] pkt_nxt;
   state_t        state;
   logic          do_wr;
   logic          do_rd;
   logic          wr_last;
   logic          rd_last;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head      = mem[rd_ptr];
   assign o_full    = (count == CW'(DEPTH));
   assign o_empty   = (count == '0);
   assign o_s_ready = !o_full;
   assign o_m_valid = (PACKET_MODE != 0) ? ((state == FORWARD) && !o_empty) : !o_empty;

   // Fields are forced to zero while nothing is presented so that reset and
   // idle never expose stale or uninitialised storage.
   assign {o_m_id, o_m_data, o_m_last} = o_m_valid ? head : '0;

   assign do_wr   = i_s_valid && o_s_ready;
   assign do_rd   = o_m_valid && i_m_ready;
   assign wr_last = do_wr && i_s_last;
   assign rd_last = do_rd && head[0];

   always_comb begin
      count_nxt = count;
      if (do_wr && !do_rd)
         count_nxt = count + CW'(1);
      else if (do_rd && !do_wr)
         count_nxt = count - CW'(1);

      pkt_nxt = pkt_count;
      if (wr_last && !rd_last)
         pkt_nxt = pkt_count + CW'(1);
      else if (rd_last && !wr_last)
         pkt_nxt = pkt_count - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (do_wr)
         mem[wr_ptr] <= {i_s_id, i_s_data, i_s_last};
   end

   // The FSM looks at next-cycle counters so valid rises in the cycle right
   // after the completing last beat (or the filling beat) is written. A full
   // buffer without a complete packet forwards cut-through until that
   // packet's last beat leaves.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkt_count <= '0;
         state     <= HOLD;
      end else begin
         if (do_wr)
            wr_ptr <= next_ptr(wr_ptr);
         if (do_rd)
            rd_ptr <= next_ptr(rd_ptr);
         count     <= count_nxt;
         pkt_count <= pkt_nxt;
         case (state)
            HOLD: begin
               if ((pkt_nxt != '0) || (count_nxt == CW'(DEPTH)))
                  state <= FORWARD;
            end
            FORWARD: begin
               if (rd_last && (pkt_nxt == '0) && (count_nxt != CW'(DEPTH)))
                  state <= HOLD;
            end
            default: state <= HOLD;
         endcase
      end
   end

`ifdef PZCOREBUS_RESPONSE_BUFFER_STATUS_EN
   assign o_occupancy    = count;
   assign o_packet_count = pkt_count;
`endif

endmodule

// File: tb/tb_pzcorebus_response_buffer.sv
// tb/tb_pzcorebus_response_buffer.sv - self-checking bench for pzcorebus_response_buffer

module tb_pzcorebus_response_buffer;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // a: DEPTH=4 streaming, p: DEPTH=4 packet mode, c: DEPTH=3 streaming
   logic a_sv = 0, a_sr, a_sl = 0, a_mv, a_mr = 0, a_ml, a_e, a_f;
   logic [7:0] a_sid = 0, a_mid;
   logic [31:0] a_sd = 0, a_md;
   logic p_sv = 0, p_sr, p_sl = 0, p_mv, p_mr = 0, p_ml, p_e, p_f;
   logic [7:0] p_sid = 0, p_mid;
   logic [31:0] p_sd = 0, p_md;
   logic c_sv = 0, c_sr, c_sl = 0, c_mv, c_mr = 0, c_ml, c_e, c_f;
   logic [7:0] c_sid = 0, c_mid;
   logic [31:0] c_sd = 0, c_md;

   pzcorebus_response_buffer #(.ID_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(0)) u_a (
      .i_clk(clk), .i_rst(rst), .i_s_valid(a_sv), .o_s_ready(a_sr), .i_s_id(a_sid),
      .i_s_data(a_sd), .i_s_last(a_sl), .o_m_valid(a_mv), .i_m_ready(a_mr), .o_m_id(a_mid),
      .o_m_data(a_md), .o_m_last(a_ml), .o_empty(a_e), .o_full(a_f));

   pzcorebus_response_buffer #(.ID_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1)) u_p (
      .i_clk(clk), .i_rst(rst), .i_s_valid(p_sv), .o_s_ready(p_sr), .i_s_id(p_sid),
      .i_s_data(p_sd), .i_s_last(p_sl), .o_m_valid(p_mv), .i_m_ready(p_mr), .o_m_id(p_mid),
      .o_m_data(p_md), .o_m_last(p_ml), .o_empty(p_e), .o_full(p_f));

   pzcorebus_response_buffer #(.ID_WIDTH(8), .DATA_WIDTH(32), .DEPTH(3), .PACKET_MODE(0)) u_c (
      .i_clk(clk), .i_rst(rst), .i_s_valid(c_sv), .o_s_ready(c_sr), .i_s_id(c_sid),
      .i_s_data(c_sd), .i_s_last(c_sl), .o_m_valid(c_mv), .i_m_ready(c_mr), .o_m_id(c_mid),
      .o_m_data(c_md), .o_m_last(c_ml), .o_empty(c_e), .o_full(c_f));

   function automatic beat_t mk_beat(input logic last);
      beat_t b;
      b.id   = 8'($urandom);
      b.data = $urandom;
      b.last = last;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({a_mv, a_sr, a_e, a_f, a_ml, a_mid, a_md} !== {5'b01100, 8'h0, 32'h0}) begin
         n_err++;
         $display("FAIL reset_a: got mv/sr/e/f/last=%b%b%b%b%b id=%h data=%h, want 01100 0 0",
                  a_mv, a_sr, a_e, a_f, a_ml, a_mid, a_md);
      end
      n_cmp++;
      if ({p_mv, p_sr, p_e, p_f, p_ml} !== 5'b01100) begin
         n_err++;
         $display("FAIL reset_p: got %b%b%b%b%b want 01100", p_mv, p_sr, p_e, p_f, p_ml);
      end
      n_cmp++;
      if ({c_mv, c_sr, c_e, c_f, c_ml} !== 5'b01100) begin
         n_err++;
         $display("FAIL reset_c: got %b%b%b%b%b want 01100", c_mv, c_sr, c_e, c_f, c_ml);
      end
   endtask

   task automatic test_single();
      a_mr = 1; a_sv = 1; a_sid = 8'h12; a_sd = 32'hCAFE; a_sl = 1;
      n_cmp++;
      if (a_mv !== 1'b0) begin
         n_err++;
         $display("FAIL single_no_bypass: mv=%b want 0", a_mv);
      end
      tick();
      a_sv = 0;
      n_cmp++;
      if ({a_mv, a_mid, a_md, a_ml} !== {1'b1, 8'h12, 32'hCAFE, 1'b1}) begin
         n_err++;
         $display("FAIL single_out: mv=%b id=%h data=%h last=%b want 1 12 0000cafe 1",
                  a_mv, a_mid, a_md, a_ml);
      end
      tick();
      n_cmp++;
      if ({a_mv, a_e} !== 2'b01) begin
         n_err++;
         $display("FAIL single_drain: mv=%b empty=%b want 0 1", a_mv, a_e);
      end
   endtask

   task automatic test_full();
      beat_t q[$];
      beat_t b;
      int guard;
      a_mr = 0;
      for (int i = 0; i < 4; i++) begin
         b = mk_beat(1'($urandom));
         a_sv = 1; a_sid = b.id; a_sd = b.data; a_sl = b.last;
         tick();
         q.push_back(b);
      end
      n_cmp++;
      if ({a_f, a_sr, a_mv} !== 3'b101) begin
         n_err++;
         $display("FAIL full_flags: full=%b ready=%b mv=%b want 1 0 1", a_f, a_sr, a_mv);
      end
      b = mk_beat(1'b1);
      a_sid = b.id; a_sd = b.data; a_sl = b.last;
      tick();
      n_cmp++;
      if ({a_f, a_mid, a_md, a_ml} !== {1'b1, q[0]}) begin
         n_err++;
         $display("FAIL full_hold: full=%b head=%h/%h want 1 %h/%h", a_f, a_mid, a_md, q[0].id, q[0].data);
      end
      a_mr = 1;
      tick();
      void'(q.pop_front());
      n_cmp++;
      if ({a_f, a_sr, a_mid, a_md, a_ml} !== {2'b01, q[0]}) begin
         n_err++;
         $display("FAIL full_read_frees: full=%b ready=%b head=%h want 0 1 %h", a_f, a_sr, a_mid, q[0].id);
      end
      a_mr = 0;
      tick();
      q.push_back(b);
      a_sv = 0;
      n_cmp++;
      if ({a_f, a_sr} !== 2'b10) begin
         n_err++;
         $display("FAIL full_fifth_accept: full=%b ready=%b want 1 0", a_f, a_sr);
      end
      a_mr = 1;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         if (a_mv) begin
            b = q.pop_front();
            n_cmp++;
            if ({a_mid, a_md, a_ml} !== b) begin
               n_err++;
               $display("FAIL full_drain: got %h/%h/%b want %h/%h/%b", a_mid, a_md, a_ml, b.id, b.data, b.last);
            end
         end
         tick();
         guard++;
      end
      n_cmp++;
      if (q.size() != 0 || a_e !== 1'b1) begin
         n_err++;
         $display("FAIL full_drain_done: left=%0d empty=%b want 0 1", q.size(), a_e);
      end
   endtask

   task automatic test_wrap_random();
      beat_t src[30];
      beat_t q[$];
      beat_t b;
      int sent = 0, got = 0, cyc = 0;
      logic w, r;
      for (int i = 0; i < 30; i++) src[i] = mk_beat(1'($urandom));
      while (got < 30 && cyc < 600) begin
         c_mr = 1'($urandom);
         c_sv = (sent < 30) && ($urandom_range(0, 3) != 0);
         if (sent < 30) begin
            c_sid = src[sent].id; c_sd = src[sent].data; c_sl = src[sent].last;
         end
         n_cmp++;
         if ({c_sr, c_f, c_e, c_mv} !== {q.size() < 3, q.size() == 3, q.size() == 0, q.size() > 0}) begin
            n_err++;
            $display("FAIL wrap_flags: ready/full/empty/mv=%b%b%b%b occupancy=%0d", c_sr, c_f, c_e, c_mv, q.size());
         end
         if (q.size() > 0) begin
            n_cmp++;
            if ({c_mid, c_md, c_ml} !== q[0]) begin
               n_err++;
               $display("FAIL wrap_data: got %h/%h/%b want %h/%h/%b", c_mid, c_md, c_ml, q[0].id, q[0].data, q[0].last);
            end
         end
         w = c_sv && (q.size() < 3);
         r = (q.size() > 0) && c_mr;
         tick();
         if (r) begin b = q.pop_front(); got++; end
         if (w) begin q.push_back(src[sent]); sent++; end
         cyc++;
      end
      c_sv = 0;
      n_cmp++;
      if (got != 30) begin
         n_err++;
         $display("FAIL wrap_timeout: received %0d want 30", got);
      end
   endtask

   task automatic test_packet_store();
      beat_t b[3];
      for (int i = 0; i < 3; i++) b[i] = mk_beat(i == 2);
      p_mr = 1;
      for (int i = 0; i < 3; i++) begin
         p_sv = 1; p_sid = b[i].id; p_sd = b[i].data; p_sl = b[i].last;
         tick();
         if (i < 2) begin
            n_cmp++;
            if (p_mv !== 1'b0) begin
               n_err++;
               $display("FAIL pkt_hold_beat%0d: mv=%b want 0", i, p_mv);
            end
         end
      end
      p_sv = 0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({p_mv, p_mid, p_md, p_ml} !== {1'b1, b[i]}) begin
            n_err++;
            $display("FAIL pkt_fwd_beat%0d: mv=%b got %h/%h want %h/%h", i, p_mv, p_mid, p_md, b[i].id, b[i].data);
         end
         tick();
      end
      n_cmp++;
      if ({p_mv, p_e} !== 2'b01) begin
         n_err++;
         $display("FAIL pkt_store_end: mv=%b empty=%b want 0 1", p_mv, p_e);
      end
   endtask

   task automatic test_packet_cut();
      beat_t src[6];
      beat_t x, y;
      int sent = 0, got = 0, cyc = 0;
      logic w, r;
      for (int i = 0; i < 6; i++) src[i] = mk_beat(i == 5);
      p_mr = 1;
      while (got < 6 && cyc < 60) begin
         p_sv = (sent < 6);
         if (sent < 6) begin
            p_sid = src[sent].id; p_sd = src[sent].data; p_sl = src[sent].last;
         end
         if (got == 0 && sent < 4) begin
            n_cmp++;
            if (p_mv !== 1'b0) begin
               n_err++;
               $display("FAIL cut_hold: mv=%b want 0 with %0d beats stored", p_mv, sent);
            end
         end
         if (got == 0 && sent == 4) begin
            n_cmp++;
            if (p_mv !== 1'b1) begin
               n_err++;
               $display("FAIL cut_fwd_on_full: mv=%b want 1", p_mv);
            end
         end
         r = p_mv;
         if (p_mv) begin
            n_cmp++;
            if ({p_mid, p_md, p_ml} !== src[got]) begin
               n_err++;
               $display("FAIL cut_order: beat %0d got %h/%h want %h/%h", got, p_mid, p_md, src[got].id, src[got].data);
            end
         end
         w = p_sv && p_sr;
         tick();
         if (r) got++;
         if (w) sent++;
         cyc++;
      end
      p_sv = 0;
      n_cmp++;
      if (got != 6 || p_e !== 1'b1) begin
         n_err++;
         $display("FAIL cut_done: received %0d empty=%b want 6 1", got, p_e);
      end
      x = mk_beat(1'b0);
      y = mk_beat(1'b1);
      p_sv = 1; p_sid = x.id; p_sd = x.data; p_sl = x.last;
      tick();
      p_sv = 0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (p_mv !== 1'b0) begin
            n_err++;
            $display("FAIL cut_back_to_hold: mv=%b want 0", p_mv);
         end
         tick();
      end
      p_sv = 1; p_sid = y.id; p_sd = y.data; p_sl = y.last;
      tick();
      p_sv = 0;
      n_cmp++;
      if ({p_mv, p_mid, p_md} !== {1'b1, x.id, x.data}) begin
         n_err++;
         $display("FAIL cut_next_packet: mv=%b id=%h want 1 %h", p_mv, p_mid, x.id);
      end
      tick();
      tick();
   endtask

   task automatic test_packet_random();
      beat_t src[$];
      beat_t st[$];
      beat_t b;
      int sent = 0, got = 0, cyc = 0, len;
      logic w, r, has_last;
      for (int k = 0; k < 10; k++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) src.push_back(mk_beat(i == len - 1));
      end
      while (got < src.size() && cyc < 3000) begin
         p_mr = ($urandom_range(0, 3) != 0);
         p_sv = (sent < src.size()) && ($urandom_range(0, 2) != 0);
         if (sent < src.size()) begin
            p_sid = src[sent].id; p_sd = src[sent].data; p_sl = src[sent].last;
         end
         has_last = 0;
         foreach (st[i]) if (st[i].last) has_last = 1;
         if (has_last || st.size() == 4) begin
            n_cmp++;
            if (p_mv !== 1'b1) begin
               n_err++;
               $display("FAIL prand_must_fwd: mv=%b want 1 (stored=%0d complete=%b)", p_mv, st.size(), has_last);
            end
         end
         n_cmp++;
         if (p_sr !== (st.size() < 4)) begin
            n_err++;
            $display("FAIL prand_ready: ready=%b occupancy=%0d", p_sr, st.size());
         end
         r = p_mv && p_mr;
         if (p_mv) begin
            n_cmp++;
            if (st.size() == 0 || {p_mid, p_md, p_ml} !== st[0]) begin
               n_err++;
               $display("FAIL prand_data: got %h/%h/%b stored=%0d", p_mid, p_md, p_ml, st.size());
            end
         end
         w = p_sv && (st.size() < 4);
         tick();
         if (r && st.size() > 0) begin b = st.pop_front(); got++; end
         if (w) begin st.push_back(src[sent]); sent++; end
         cyc++;
      end
      p_sv = 0;
      n_cmp++;
      if (got != src.size()) begin
         n_err++;
         $display("FAIL prand_timeout: received %0d want %0d", got, src.size());
      end
   endtask

   task automatic test_reset_mid();
      beat_t b;
      a_mr = 0;
      for (int i = 0; i < 2; i++) begin
         b = mk_beat(1'b1);
         a_sv = 1; a_sid = b.id; a_sd = b.data; a_sl = b.last;
         tick();
      end
      a_sv = 0;
      n_cmp++;
      if (a_mv !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre: mv=%b want 1", a_mv);
      end
      #2 rst = 1;
      #1;
      n_cmp++;
      if ({a_mv, a_e, a_f, a_sr, a_mid, a_md, a_ml} !== {4'b0101, 41'h0}) begin
         n_err++;
         $display("FAIL rstmid_async: mv/e/f/sr=%b%b%b%b id=%h want 0101 00", a_mv, a_e, a_f, a_sr, a_mid);
      end
      @(negedge clk);
      rst = 0;
      a_mr = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({a_mv, a_e} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_stale: mv=%b empty=%b want 0 1", a_mv, a_e);
         end
      end
      b = mk_beat(1'b0);
      a_sv = 1; a_sid = b.id; a_sd = b.data; a_sl = b.last;
      tick();
      a_sv = 0;
      n_cmp++;
      if ({a_mv, a_mid, a_md, a_ml} !== {1'b1, b}) begin
         n_err++;
         $display("FAIL rstmid_new: mv=%b got %h/%h want 1 %h/%h", a_mv, a_mid, a_md, b.id, b.data);
      end
      tick();
   endtask

   initial begin
      rst = 1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 0;
      tick();
      test_reset();
      test_single();
      test_full();
      test_wrap_random();
      test_packet_store();
      test_packet_cut();
      test_packet_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
